mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control unit for the MIPS datapath.
- Replaces the single-cycle combinational decoder with a 5-state FSM (IF, ID, EX, MEM, WB).
- Lets PC, register file, ALU and one unified memory be shared across cycles of one instruction.
- Op/Funct come from the datapath's instruction register, which this block loads via IRWrite.
- Drives every datapath select and write enable each cycle.

Parameters:
ALU_NOP, 4'd0, ALUOp code: no operation
ALU_ADD, 4'd1, ALUOp code: A+B
ALU_SUB, 4'd2, ALUOp code: A-B
ALU_AND, 4'd3, ALUOp code: A&B
ALU_OR, 4'd4, ALUOp code: A|B
ALU_SLT, 4'd5, ALUOp code: signed A<B
ALU_SLL, 4'd6, ALUOp code: B<<A[4:0]
ALU_SRL, 4'd7, ALUOp code: B>>A[4:0]

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  reset: asynchronous, active-low
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag, same cycle
PCWrite  out  1  PC loads NPC at next edge
IRWrite  out  1  IR loads memory read data
IorD  out  1  memory address: 0=PC, 1=aluout register
MemWrite  out  1  memory write strobe
RegWrite  out  1  register file write
EXTOp  out  1  1=sign extend, 0=zero extend Imm16
ALUOp  out  4  ALU operation (parameter codes)
AREGSel  out  1  ALU A: 0=RD1 register, 1=shamt
ALUSrc  out  1  ALU B: 0=RD2 register, 1=Imm32
NPCOp  out  2  00=PC+4, 01=branch, 10=jump26, 11=jr(RD1)
GPRSel  out  2  write address: 00=rd, 01=rt, 10=r31
WDSel  out  2  write data: 00=aluout, 01=MDR, 10=PC (already PC+4)
state  out  3  FSM state for debug: IF=0, ID=1, EX=2, MEM=3, WB=4
instr_done  out  1  high in the last cycle of each instruction

Behaviour:
Reset and defaults:
- rst=0 forces state=IF asynchronously.
- While rst=0, all write enables (PCWrite, IRWrite, MemWrite, RegWrite) and instr_done are 0, and all selects are 0.
- Outputs are combinational from state, Op, Funct and Zero.
- Any output not listed for a state is 0.

Decoding:
- Supported: R-type (Op 000000) with Funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010, jr 001000.
- Also lw 100011, sw 101011, beq 000100, addi 001000, ori 001101, j 000010, jal 000011.
- EXTOp=1 for addi/lw/sw/beq; 0 otherwise.

IF (every instruction):
- IRWrite=1, PCWrite=1, NPCOp=00, IorD=0. Next state ID.

ID:
- j: PCWrite=1, NPCOp=10, instr_done=1. Next state IF.
- jal: as j, plus RegWrite=1, GPRSel=10, WDSel=10. The written value is the PC+4 loaded in IF. Next state IF.
- jr: PCWrite=1, NPCOp=11, instr_done=1. Next state IF.
- Unsupported Op, or R-type with unsupported Funct: instr_done=1, no writes. Next state IF (treated as NOP).
- Otherwise: next state EX.

EX:
- R-type ALU ops: ALUSrc=0, ALUOp per Funct. sll/srl also set AREGSel=1. Next state WB.
- addi: ALUSrc=1, ALU_ADD. ori: ALUSrc=1, ALU_OR. Next state WB.
- lw/sw: ALUSrc=1, ALU_ADD. Next state MEM.
- beq: ALU_SUB, ALUSrc=0, NPCOp=01, PCWrite=Zero, instr_done=1. Next state IF.

MEM:
- IorD=1.
- sw: MemWrite=1, instr_done=1. Next state IF.
- lw: next state WB.

WB:
- RegWrite=1, instr_done=1. Next state IF.
- R-type: GPRSel=00, WDSel=00.
- addi/ori: GPRSel=01, WDSel=00.
- lw: GPRSel=01, WDSel=01.

Latency in cycles: j/jal/jr/NOP=2, beq=3, R/addi/ori/sw=4, lw=5.

Boundary conditions:
- Reset mid-instruction aborts it immediately. No partial write occurs after rst falls.
- Restart is from IF at the first rising edge with rst=1.
- Illegal state codes 5-7 go to IF on the next edge with all enables 0.

Test Plan:
- Reset: rst=0 held 3 cycles -> state=0, all write enables 0. Release -> IF with IRWrite=1, PCWrite=1, NPCOp=00.
- add (Op 0, Funct 100000) -> states 0,1,2,4,0. WB shows RegWrite=1, GPRSel=00, WDSel=00. EX shows ALUOp=1. instr_done only in WB.
- lw (100011) -> 5 cycles; MEM has IorD=1, MemWrite=0; WB has GPRSel=01, WDSel=01. sw (101011) -> MEM has MemWrite=1, ends after 4 cycles.
- beq with Zero=1 -> EX has PCWrite=1, NPCOp=01, ALUOp=2. With Zero=0 -> PCWrite=0. Both return to IF after 3 cycles.
- jal (000011) -> ID has PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10. Op 111111 -> 2-cycle NOP, no write enables asserted.
- sll -> EX has AREGSel=1, ALUOp=6. Drop rst in EX of an lw -> state=0 asynchronously; no MemWrite/RegWrite pulse; next instruction fetched after release.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: a five-state IF/ID/EX/MEM/WB FSM that drives
// every datapath select and write enable, with outputs decoded from state, Op, Funct and Zero.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic       AREGSel,
  output logic       ALUSrc,
  output logic [1:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       instr_done
);

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic       is_rtype_s, is_lw_s, is_sw_s, is_beq_s, is_addi_s, is_ori_s;
  logic       is_j_s, is_jal_s, is_jr_s, is_shift_s, r_alu_s, legal_s;
  logic [3:0] r_aluop_s;

  logic       pc_write_s, ir_write_s, iord_s, mem_write_s, reg_write_s, ext_op_s;
  logic [3:0] alu_op_s;
  logic       areg_sel_s, alu_src_s, instr_done_s;
  logic [1:0] npc_op_s, gpr_sel_s, wd_sel_s;

  // ALU operation for an R-type Funct; non-ALU functs map to NOP
  function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_to_alu = ALU_ADD;
      6'b100010: funct_to_alu = ALU_SUB;
      6'b100100: funct_to_alu = ALU_AND;
      6'b100101: funct_to_alu = ALU_OR;
      6'b101010: funct_to_alu = ALU_SLT;
      6'b000000: funct_to_alu = ALU_SLL;
      6'b000010: funct_to_alu = ALU_SRL;
      default:   funct_to_alu = ALU_NOP;
    endcase
  endfunction

  // Instruction decode from the IR fields
  always_comb begin
    is_rtype_s = (Op == 6'b000000);
    is_lw_s    = (Op == 6'b100011);
    is_sw_s    = (Op == 6'b101011);
    is_beq_s   = (Op == 6'b000100);
    is_addi_s  = (Op == 6'b001000);
    is_ori_s   = (Op == 6'b001101);
    is_j_s     = (Op == 6'b000010);
    is_jal_s   = (Op == 6'b000011);
    r_aluop_s  = funct_to_alu(Funct);
    is_jr_s    = is_rtype_s && (Funct == 6'b001000);
    r_alu_s    = is_rtype_s && (r_aluop_s != ALU_NOP);
    is_shift_s = is_rtype_s && ((Funct == 6'b000000) || (Funct == 6'b000010));
    legal_s    = r_alu_s || is_jr_s || is_lw_s || is_sw_s || is_beq_s ||
                 is_addi_s || is_ori_s || is_j_s || is_jal_s;
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d      = S_IF;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    iord_s       = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    alu_op_s     = ALU_NOP;
    areg_sel_s   = 1'b0;
    alu_src_s    = 1'b0;
    npc_op_s     = 2'b00;
    gpr_sel_s    = 2'b00;
    wd_sel_s     = 2'b00;
    instr_done_s = 1'b0;
    ext_op_s     = 1'b0;
    case (state_q)
      S_IF: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        state_d    = S_ID;
      end
      S_ID: begin
        if (is_j_s || is_jal_s) begin
          pc_write_s   = 1'b1;
          npc_op_s     = 2'b10;
          instr_done_s = 1'b1;
          reg_write_s  = is_jal_s;
          gpr_sel_s    = is_jal_s ? 2'b10 : 2'b00;
          wd_sel_s     = is_jal_s ? 2'b10 : 2'b00;
        end else if (is_jr_s) begin
          pc_write_s   = 1'b1;
          npc_op_s     = 2'b11;
          instr_done_s = 1'b1;
        end else if (!legal_s) begin
          instr_done_s = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (r_alu_s) begin
          alu_op_s   = r_aluop_s;
          areg_sel_s = is_shift_s;
          state_d    = S_WB;
        end else if (is_addi_s || is_ori_s) begin
          alu_src_s = 1'b1;
          alu_op_s  = is_ori_s ? ALU_OR : ALU_ADD;
          state_d   = S_WB;
        end else if (is_lw_s || is_sw_s) begin
          alu_src_s = 1'b1;
          alu_op_s  = ALU_ADD;
          state_d   = S_MEM;
        end else if (is_beq_s) begin
          alu_op_s     = ALU_SUB;
          npc_op_s     = 2'b01;
          pc_write_s   = Zero;
          instr_done_s = 1'b1;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        iord_s = 1'b1;
        if (is_sw_s) begin
          mem_write_s  = 1'b1;
          instr_done_s = 1'b1;
        end else if (is_lw_s) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        if (is_lw_s) begin
          gpr_sel_s = 2'b01;
          wd_sel_s  = 2'b01;
        end else if (is_addi_s || is_ori_s) begin
          gpr_sel_s = 2'b01;
        end else begin
          gpr_sel_s = 2'b00;
        end
      end
      default: begin
        state_d = S_IF;
      end
    endcase
    // Extension mode is a property of the instruction, valid in every legal state
    if (state_q <= S_WB) begin
      ext_op_s = is_addi_s || is_lw_s || is_sw_s || is_beq_s;
    end else begin
      ext_op_s = 1'b0;
    end
  end

  // Outputs held quiet while reset is asserted
  always_comb begin
    if (!rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      EXTOp      = 1'b0;
      ALUOp      = ALU_NOP;
      AREGSel    = 1'b0;
      ALUSrc     = 1'b0;
      NPCOp      = 2'b00;
      GPRSel     = 2'b00;
      WDSel      = 2'b00;
      instr_done = 1'b0;
    end else begin
      PCWrite    = pc_write_s;
      IRWrite    = ir_write_s;
      IorD       = iord_s;
      MemWrite   = mem_write_s;
      RegWrite   = reg_write_s;
      EXTOp      = ext_op_s;
      ALUOp      = alu_op_s;
      AREGSel    = areg_sel_s;
      ALUSrc     = alu_src_s;
      NPCOp      = npc_op_s;
      GPRSel     = gpr_sel_s;
      WDSel      = wd_sel_s;
      instr_done = instr_done_s;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each cycle's expected control word is queued
// when the stimulus is applied and checked against the DUT at the falling edge.
module tb_mc_ctrl;

  logic       clk, rst, Zero;
  logic [5:0] Op, Funct;
  logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp, AREGSel, ALUSrc, instr_done;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  logic [21:0] sb_q[$];
  logic [21:0] obs_s;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .AREGSel(AREGSel),
    .ALUSrc(ALUSrc), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
    .state(state), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_s = {state, PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp, ALUOp,
                  AREGSel, ALUSrc, NPCOp, GPRSel, WDSel, instr_done};

  // Packs one expected control word in the same field order as obs_s
  function automatic logic [21:0] ev(input int st, input int pcw, input int irw, input int iord,
                                     input int mw, input int rw, input int ext, input int aop,
                                     input int areg, input int src, input int npc, input int gpr,
                                     input int wd, input int done);
    logic [2:0] s3;
    logic [3:0] a4;
    logic [1:0] n2, g2, w2;
    s3 = st[2:0]; a4 = aop[3:0]; n2 = npc[1:0]; g2 = gpr[1:0]; w2 = wd[1:0];
    ev = {s3, pcw[0], irw[0], iord[0], mw[0], rw[0], ext[0], a4, areg[0], src[0], n2, g2, w2, done[0]};
  endfunction

  task automatic check(input string tag);
    logic [21:0] e;
    e = sb_q.pop_front();
    total++;
    assert (obs_s === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_s, e);
    end
  endtask

  // One full clock cycle: queue the expectation, check at negedge, advance past posedge
  task automatic cyc(input string tag, input logic [21:0] e);
    sb_q.push_back(e);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
    Op = op; Funct = fn; Zero = z;
  endtask

  initial begin
    rst = 1'b0;
    set_ir(6'b000000, 6'b100000, 1'b0);
    for (int i = 0; i < 3; i++) cyc("reset", ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;

    // add
    cyc("add_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add_id", ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add_ex", ev(2,0,0,0,0,0,0,1,0,0,0,0,0,0));
    cyc("add_wb", ev(4,0,0,0,0,1,0,0,0,0,0,0,0,1));

    // lw
    set_ir(6'b100011, 6'b000000, 1'b0);
    cyc("lw_if",  ev(0,1,1,0,0,0,1,0,0,0,0,0,0,0));
    cyc("lw_id",  ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("lw_ex",  ev(2,0,0,0,0,0,1,1,0,1,0,0,0,0));
    cyc("lw_mem", ev(3,0,0,1,0,0,1,0,0,0,0,0,0,0));
    cyc("lw_wb",  ev(4,0,0,0,0,1,1,0,0,0,0,1,1,1));

    // sw
    set_ir(6'b101011, 6'b000000, 1'b0);
    cyc("sw_if",  ev(0,1,1,0,0,0,1,0,0,0,0,0,0,0));
    cyc("sw_id",  ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("sw_ex",  ev(2,0,0,0,0,0,1,1,0,1,0,0,0,0));
    cyc("sw_mem", ev(3,0,0,1,1,0,1,0,0,0,0,0,0,1));

    // beq taken, then not taken
    set_ir(6'b000100, 6'b000000, 1'b1);
    cyc("beqt_if", ev(0,1,1,0,0,0,1,0,0,0,0,0,0,0));
    cyc("beqt_id", ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("beqt_ex", ev(2,1,0,0,0,0,1,2,0,0,1,0,0,1));
    set_ir(6'b000100, 6'b000000, 1'b0);
    cyc("beqn_if", ev(0,1,1,0,0,0,1,0,0,0,0,0,0,0));
    cyc("beqn_id", ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("beqn_ex", ev(2,0,0,0,0,0,1,2,0,0,1,0,0,1));

    // jal, j, jr, illegal op, unsupported funct
    set_ir(6'b000011, 6'b000000, 1'b0);
    cyc("jal_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("jal_id", ev(1,1,0,0,0,1,0,0,0,0,2,2,2,1));
    set_ir(6'b000010, 6'b000000, 1'b0);
    cyc("j_if",   ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("j_id",   ev(1,1,0,0,0,0,0,0,0,0,2,0,0,1));
    set_ir(6'b000000, 6'b001000, 1'b0);
    cyc("jr_if",  ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("jr_id",  ev(1,1,0,0,0,0,0,0,0,0,3,0,0,1));
    set_ir(6'b111111, 6'b000000, 1'b0);
    cyc("nop_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("nop_id", ev(1,0,0,0,0,0,0,0,0,0,0,0,0,1));
    set_ir(6'b000000, 6'b111111, 1'b0);
    cyc("badf_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("badf_id", ev(1,0,0,0,0,0,0,0,0,0,0,0,0,1));

    // sll, srl, ori, addi
    set_ir(6'b000000, 6'b000000, 1'b0);
    cyc("sll_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("sll_id", ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("sll_ex", ev(2,0,0,0,0,0,0,6,1,0,0,0,0,0));
    cyc("sll_wb", ev(4,0,0,0,0,1,0,0,0,0,0,0,0,1));
    set_ir(6'b000000, 6'b000010, 1'b0);
    cyc("srl_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("srl_id", ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("srl_ex", ev(2,0,0,0,0,0,0,7,1,0,0,0,0,0));
    cyc("srl_wb", ev(4,0,0,0,0,1,0,0,0,0,0,0,0,1));
    set_ir(6'b000000, 6'b101010, 1'b0);
    cyc("slt_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("slt_id", ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("slt_ex", ev(2,0,0,0,0,0,0,5,0,0,0,0,0,0));
    cyc("slt_wb", ev(4,0,0,0,0,1,0,0,0,0,0,0,0,1));
    set_ir(6'b001101, 6'b000000, 1'b0);
    cyc("ori_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("ori_id", ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("ori_ex", ev(2,0,0,0,0,0,0,4,0,1,0,0,0,0));
    cyc("ori_wb", ev(4,0,0,0,0,1,0,0,0,0,0,1,0,1));
    set_ir(6'b001000, 6'b000000, 1'b0);
    cyc("addi_if", ev(0,1,1,0,0,0,1,0,0,0,0,0,0,0));
    cyc("addi_id", ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("addi_ex", ev(2,0,0,0,0,0,1,1,0,1,0,0,0,0));
    cyc("addi_wb", ev(4,0,0,0,0,1,1,0,0,0,0,1,0,1));

    // lw aborted by reset during EX
    set_ir(6'b100011, 6'b000000, 1'b0);
    cyc("abt_if", ev(0,1,1,0,0,0,1,0,0,0,0,0,0,0));
    cyc("abt_id", ev(1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    sb_q.push_back(ev(2,0,0,0,0,0,1,1,0,1,0,0,0,0));
    @(negedge clk);
    check("abt_ex");
    #2;
    rst = 1'b0;
    #1;
    sb_q.push_back(ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    check("abt_async");
    @(posedge clk);
    #1;
    cyc("abt_hold", ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    set_ir(6'b000000, 6'b100000, 1'b0);
    cyc("rst_if", ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("rst_id", ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("rst_ex", ev(2,0,0,0,0,0,0,1,0,0,0,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
